// File: rtl/tl_ul_responder.sv
`default_nettype none
// ============================================================================
// Module  : tl_ul_responder
// Brief   : TL-UL register-window responder, one-entry response register
// Rev     : 1.0  initial release
// ============================================================================
module tl_ul_responder #(
  parameter logic [29:0] BASE   = 30'h0200_0000,
  parameter int          NWORDS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [2:0]  a_size,
  input  logic [3:0]  a_source,
  input  logic [29:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  output logic        a_ready,
  output logic        d_valid,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [2:0]  d_size,
  output logic [3:0]  d_source,
  output logic        d_denied,
  output logic [31:0] d_data,
  output logic        d_corrupt,
  input  logic        d_ready
);

  localparam int          C_IDXW = $clog2(NWORDS);
  localparam logic [29:0] C_SPAN = 30'(4 * NWORDS);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [31:0]        mem_q [NWORDS];
  logic [31:0]        mem_d [NWORDS];
  logic [2:0]         d_opcode_q, d_opcode_d;
  logic [2:0]         d_size_q, d_size_d;
  logic [3:0]         d_source_q, d_source_d;
  logic               d_denied_q, d_denied_d;
  logic [31:0]        d_data_q, d_data_d;
  logic               d_corrupt_q, d_corrupt_d;

  logic               a_fire, d_fire;
  logic [29:0]        offset;
  logic               in_range, misaligned, op_get, op_put, op_data_rsp, denied;
  logic [C_IDXW-1:0]  word_idx;

  assign d_valid   = (state_q == FULL);
  assign a_ready   = !d_valid || d_ready;
  assign a_fire    = a_valid && a_ready;
  assign d_fire    = d_valid && d_ready;
  assign d_param   = 2'b00;
  assign d_opcode  = d_opcode_q;
  assign d_size    = d_size_q;
  assign d_source  = d_source_q;
  assign d_denied  = d_denied_q;
  assign d_data    = d_data_q;
  assign d_corrupt = d_corrupt_q;

  // Request decode; oversize requests fold into the misaligned term.
  always_comb begin
    offset      = a_address - BASE;
    in_range    = (a_address >= BASE) && (offset < C_SPAN);
    word_idx    = offset[C_IDXW+1:2];
    op_get      = (a_opcode == 3'd4);
    op_put      = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    op_data_rsp = (a_opcode == 3'd2) || (a_opcode == 3'd3) || (a_opcode == 3'd4);
    case (a_size)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = a_address[0];
      3'd2:    misaligned = |a_address[1:0];
      default: misaligned = 1'b1;
    endcase
    denied = !in_range || misaligned || (a_param != 3'd0) || !(op_get || op_put);
  end

  always_comb begin
    mem_d = mem_q;
    if (a_fire && !denied && op_put) begin
      for (int i = 0; i < 4; i++) begin
        if (a_mask[i]) mem_d[word_idx][8*i +: 8] = a_data[8*i +: 8];
      end
    end
  end

  // Get data comes from mem_q, i.e. the word before this edge's write.
  always_comb begin
    state_d     = state_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_denied_d  = d_denied_q;
    d_data_d    = d_data_q;
    d_corrupt_d = d_corrupt_q;
    if (a_fire) begin
      state_d     = FULL;
      d_opcode_d  = op_data_rsp ? 3'd1 : 3'd0;
      d_size_d    = a_size;
      d_source_d  = a_source;
      d_denied_d  = denied;
      d_data_d    = (!denied && op_get) ? mem_q[word_idx] : 32'h0;
      d_corrupt_d = denied && op_data_rsp;
    end else if (d_fire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      d_opcode_q  <= 3'd0;
      d_size_q    <= 3'd0;
      d_source_q  <= 4'd0;
      d_denied_q  <= 1'b0;
      d_data_q    <= 32'h0;
      d_corrupt_q <= 1'b0;
      for (int i = 0; i < NWORDS; i++) mem_q[i] <= 32'h0;
    end else begin
      state_q     <= state_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_denied_q  <= d_denied_d;
      d_data_q    <= d_data_d;
      d_corrupt_q <= d_corrupt_d;
      for (int i = 0; i < NWORDS; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_tl_ul_responder
// Brief   : scoreboard bench for tl_ul_responder with a reference memory model
// Rev     : 1.0  initial release
// ============================================================================
module tb_tl_ul_responder;

  localparam logic [29:0] BASE = 30'h0200_0000;
  localparam int          NW   = 16;

  logic        clock, reset;
  logic        a_valid, a_ready, d_valid, d_ready, d_denied, d_corrupt;
  logic [2:0]  a_opcode, a_param, a_size, d_opcode, d_size;
  logic [3:0]  a_source, a_mask, d_source;
  logic [29:0] a_address;
  logic [31:0] a_data, d_data;
  logic [1:0]  d_param;

  tl_ul_responder #(.BASE(BASE), .NWORDS(NW)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .a_ready(a_ready),
    .d_valid(d_valid), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt),
    .d_ready(d_ready)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic        den;
    logic [31:0] data;
    logic        corr;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] ref_mem [NW];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          fire_cyc = -10;
  int          rdy_mode = 0;   // 0: always ready, 1: stalled, 2: random

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    d_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       d_ready = 1'b1;
        1:       d_ready = 1'b0;
        default: d_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] d_bundle();
    return {18'b0, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt};
  endfunction

  task automatic scramble_a();
    a_opcode  = 3'($urandom);
    a_param   = 3'($urandom);
    a_size    = 3'($urandom);
    a_source  = 4'($urandom);
    a_address = 30'($urandom);
    a_mask    = 4'($urandom);
    a_data    = $urandom;
  endtask

  // Reference model: TL-UL access rules applied to a plain word array.
  task automatic model_accept(input logic [2:0] op, input logic [29:0] addr,
                              input logic [2:0] sz, input logic [3:0] mask,
                              input logic [31:0] data, input logic [3:0] src,
                              input logic [2:0] prm);
    longint a, lo, hi;
    bit     mis, den;
    int     w;
    rsp_t   e;
    a   = longint'(addr);
    lo  = longint'(BASE);
    hi  = lo + 4 * NW;
    mis = (sz > 3'd2) ? 1'b1 : ((a % (longint'(1) << sz)) != 0);
    den = (a < lo) || (a >= hi) || mis || (prm != 3'd0) ||
          !(op == 3'd0 || op == 3'd1 || op == 3'd4);
    e.op   = (op == 3'd2 || op == 3'd3 || op == 3'd4) ? 3'd1 : 3'd0;
    e.size = sz;
    e.src  = src;
    e.den  = den;
    e.corr = den && (e.op == 3'd1);
    e.data = 32'h0;
    if (!den) begin
      w = int'((a - lo) / 4);
      if (op == 3'd4) e.data = ref_mem[w];
      else for (int i = 0; i < 4; i++) if (mask[i]) ref_mem[w][8*i +: 8] = data[8*i +: 8];
    end
    sb.push_back(e);
    fire_cyc = cyc;
  endtask

  task automatic send(input logic [2:0] op, input logic [29:0] addr, input logic [2:0] sz,
                      input logic [3:0] mask, input logic [31:0] data, input logic [3:0] src,
                      input logic [2:0] prm);
    int guard;
    guard     = 0;
    a_valid   = 1'b1;
    a_opcode  = op;
    a_address = addr;
    a_size    = sz;
    a_mask    = mask;
    a_data    = data;
    a_source  = src;
    a_param   = prm;
    forever begin
      @(negedge clock);
      if (a_ready) begin
        model_accept(op, addr, sz, mask, data, src, prm);
        break;
      end
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL a_accept_timeout actual=a_ready_low required=accept");
        break;
      end
    end
    @(posedge clock);
    #1;
    a_valid = 1'b0;
    scramble_a();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      scramble_a();
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: handshake rule, latency, stability under stall, scoreboard pop.
  logic        held;
  logic [63:0] held_v;
  initial begin
    held = 1'b0;
    held_v = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        held = 1'b0;
        continue;
      end
      chk("a_ready_rule", {63'b0, a_ready}, {63'b0, (!d_valid || d_ready)});
      if (fire_cyc == cyc - 1) chk("d_latency", {63'b0, d_valid}, 64'd1);
      if (held) begin
        chk("stall_valid", {63'b0, d_valid}, 64'd1);
        chk("stall_stable", d_bundle(), held_v);
      end
      if (d_valid && d_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_d_beat actual=d_valid required=no_beat data=%h", d_data);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("d_opcode",  {61'b0, d_opcode},  {61'b0, e.op});
          chk("d_param",   {62'b0, d_param},   64'd0);
          chk("d_size",    {61'b0, d_size},    {61'b0, e.size});
          chk("d_source",  {60'b0, d_source},  {60'b0, e.src});
          chk("d_denied",  {63'b0, d_denied},  {63'b0, e.den});
          chk("d_data",    {32'b0, d_data},    {32'b0, e.data});
          chk("d_corrupt", {63'b0, d_corrupt}, {63'b0, e.corr});
        end
      end
      held   = d_valid && !d_ready;
      held_v = d_bundle();
    end
  end

  initial begin
    int n, r;
    logic [2:0]  op, sz, prm;
    logic [29:0] addr;
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
    a_valid = 1'b0;
    scramble_a();
    reset = 1'b1;
    #1;
    chk("reset_d_valid", {63'b0, d_valid}, 64'd0);
    chk("reset_d_out", d_bundle(), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_a_ready", {63'b0, a_ready}, 64'd1);
    chk("post_reset_d_valid", {63'b0, d_valid}, 64'd0);
    @(posedge clock);
    #1;

    // Put/Get round trip, then partial write
    send(3'd0, BASE + 30'd8, 3'd2, 4'hF, 32'hDEADBEEF, 4'd3, 3'd0);
    send(3'd4, BASE + 30'd8, 3'd2, 4'h0, 32'h0, 4'd5, 3'd0);
    send(3'd1, BASE + 30'd8, 3'd2, 4'b0010, 32'h0000AB00, 4'd1, 3'd0);
    send(3'd4, BASE + 30'd8, 3'd2, 4'hF, 32'h0, 4'd2, 3'd0);
    send(3'd1, BASE + 30'd13, 3'd0, 4'b0010, 32'h00005A00, 4'd6, 3'd0);
    send(3'd4, BASE + 30'd12, 3'd2, 4'hF, 32'h0, 4'd7, 3'd0);

    // Denied cases and readback of untouched storage
    send(3'd4, BASE + 30'(4 * NW), 3'd2, 4'hF, 32'h0, 4'd1, 3'd0);
    send(3'd4, BASE + 30'd8, 3'd3, 4'hF, 32'h0, 4'd2, 3'd0);
    send(3'd0, BASE + 30'd2, 3'd2, 4'hF, 32'hFFFFFFFF, 4'd3, 3'd0);
    send(3'd2, BASE + 30'd8, 3'd2, 4'hF, 32'hFFFFFFFF, 4'd4, 3'd0);
    send(3'd6, BASE + 30'd8, 3'd2, 4'hF, 32'hFFFFFFFF, 4'd5, 3'd0);
    send(3'd0, BASE + 30'd4, 3'd2, 4'hF, 32'h12345678, 4'd6, 3'd1);
    send(3'd4, BASE + 30'd8, 3'd2, 4'hF, 32'h0, 4'd8, 3'd0);
    send(3'd4, BASE, 3'd2, 4'hF, 32'h0, 4'd9, 3'd0);
    send(3'd4, BASE + 30'd4, 3'd2, 4'hF, 32'h0, 4'd10, 3'd0);

    // Stall for several cycles, then release into back-to-back traffic
    rdy_mode = 1;
    @(posedge clock);
    #1;
    send(3'd4, BASE + 30'd8, 3'd2, 4'hF, 32'h0, 4'd11, 3'd0);
    fork
      begin
        repeat (6) @(posedge clock);
        rdy_mode = 0;
      end
    join_none
    send(3'd0, BASE + 30'd16, 3'd2, 4'hF, 32'hCAFEF00D, 4'd12, 3'd0);
    send(3'd4, BASE + 30'd16, 3'd2, 4'hF, 32'h0, 4'd13, 3'd0);
    send(3'd4, BASE + 30'd8, 3'd2, 4'hF, 32'h0, 4'd14, 3'd0);
    idle(3);

    // Reset while a response is held under backpressure
    rdy_mode = 1;
    @(posedge clock);
    #1;
    send(3'd0, BASE + 30'd8, 3'd2, 4'hF, 32'h12345678, 4'd15, 3'd0);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_reset_d_valid", {63'b0, d_valid}, 64'd0);
    chk("mid_reset_d_out", d_bundle(), 64'd0);
    sb.delete();
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
    fire_cyc = -10;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rereset_a_ready", {63'b0, a_ready}, 64'd1);
    chk("rereset_d_valid", {63'b0, d_valid}, 64'd0);
    rdy_mode = 0;
    @(posedge clock);
    #1;
    send(3'd4, BASE + 30'd8, 3'd2, 4'hF, 32'h0, 4'd1, 3'd0);
    send(3'd4, BASE + 30'd16, 3'd2, 4'hF, 32'h0, 4'd2, 3'd0);

    // Random traffic with random backpressure
    rdy_mode = 2;
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       op = 3'd4;
      else if (r < 7)  op = 3'd0;
      else if (r == 7) op = 3'd1;
      else             op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) != 0) addr = BASE + 30'(4 * $urandom_range(0, NW - 1));
      else                           addr = BASE - 30'd4 + 30'($urandom_range(0, 4 * NW + 8));
      sz  = ($urandom_range(0, 6) != 0) ? 3'd2 : 3'($urandom_range(0, 7));
      prm = ($urandom_range(0, 19) != 0) ? 3'd0 : 3'($urandom_range(1, 7));
      send(op, addr, sz, 4'($urandom), $urandom, 4'($urandom), prm);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Read back every word, then drain
    for (int i = 0; i < NW; i++)
      send(3'd4, BASE + 30'(4 * i), 3'd2, 4'hF, 32'h0, 4'(i), 3'd0);
    rdy_mode = 0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    @(negedge clock);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_d_valid", {63'b0, d_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tl_ul_responder.md
TL_UL_RESPONDER -- requirements
Module: tl_ul_responder

Interface
REQ-001 SHALL have parameter BASE, default 30'h0200_0000, the word-aligned base byte address of the register window.
REQ-002 SHALL have parameter NWORDS, default 16 (power of two, 2..256), the number of 32-bit storage words.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have A-channel inputs: a_valid 1, a_opcode 3, a_param 3, a_size 3, a_source 4, a_address 30, a_mask 4, a_data 32.
REQ-006 SHALL have port a_ready  output  1  responder can accept an A beat this cycle.
REQ-007 SHALL have D-channel outputs: d_valid 1, d_opcode 3, d_param 2, d_size 3, d_source 4, d_denied 1, d_data 32, d_corrupt 1.
REQ-008 SHALL have port d_ready  input  1  initiator accepts the D beat.

Function
REQ-009 SHALL use a one-entry response register; states EMPTY (d_valid=0) and FULL (d_valid=1).
REQ-010 SHALL drive a_ready = !d_valid || d_ready (combinational), giving one A beat per cycle at full throughput.
REQ-011 SHALL define A fire = a_valid && a_ready and D fire = d_valid && d_ready.
REQ-012 SHALL on A fire load the response register and set d_valid=1 next cycle (latency exactly 1 cycle).
REQ-013 SHALL on D fire without A fire clear d_valid; D fire with A fire in the same cycle keeps d_valid=1 with the new response.
REQ-014 SHALL hold all d_* outputs stable while d_valid && !d_ready.
REQ-015 SHALL decode a_opcode: 0 PutFullData, 1 PutPartialData, 4 Get; codes 2, 3, 5 are unsupported; codes 6, 7 are illegal.
REQ-016 SHALL respond d_opcode=1 (AccessAckData) to Get and to opcode 2, 3; d_opcode=0 (AccessAck) to Put and to opcode 5; d_opcode=0 with d_denied=1 for opcodes 6, 7.
REQ-017 SHALL copy a_size to d_size and a_source to d_source; d_param SHALL always be 0.
REQ-018 SHALL mark a request denied when any of: address outside [BASE, BASE+4*NWORDS); a_size>2; a_address not aligned to 2^a_size; a_param!=0; opcode 2, 3, 5, 6, 7.
REQ-019 SHALL index storage with word = (a_address-BASE)>>2, masked to log2(NWORDS) bits.
REQ-020 SHALL on non-denied Put write each byte lane i where a_mask[i]=1 at the A fire edge; denied Puts SHALL leave storage unchanged.
REQ-021 SHALL for PutFullData ignore mask contents beyond lane selection (no mask legality check).
REQ-022 SHALL on non-denied Get capture d_data = storage word as it was before that edge's writes, all 32 bits regardless of a_mask; d_corrupt=0.
REQ-023 SHALL on denied AccessAckData drive d_data=0, d_corrupt=1, d_denied=1; on AccessAck d_corrupt=0 and d_data=0.
REQ-024 SHALL make a Put followed by a Get to the same word in the next accepted beat return the written data.
REQ-025 SHALL ignore a_* contents whenever a_valid=0.

Reset
REQ-026 SHALL on reset assertion asynchronously clear d_valid and all d_* outputs to 0 and all storage words to 0.
REQ-027 SHALL discard any pending response when reset asserts mid-operation; no D beat for that request appears after reset.
REQ-028 SHALL hold a_ready=1 and d_valid=0 in the first cycle after reset deasserts.

Verification
REQ-029 Put a_opcode=0, a_address=BASE+8, a_size=2, a_mask=4'hF, a_data=32'hDEADBEEF, a_source=3; then Get BASE+8 source 5 -> AccessAck source 3 denied 0; then AccessAckData source 5, d_data=32'hDEADBEEF, corrupt 0.
REQ-030 PutPartial mask 4'b0010 data 32'h0000AB00 to word 2 holding 32'hDEADBEEF; Get -> 32'hDEADABEF.
REQ-031 d_ready=0 for 5 cycles after a Get -> d_valid and d_data stable, a_ready=0; d_ready=1 with a new a_valid -> back-to-back D beats, one per cycle, none lost or duplicated.
REQ-032 Get BASE+4*NWORDS; Get a_size=3; Put a_address=BASE+2 a_size=2; opcode 2 -> all denied=1; Get/opcode-2 denied have d_data=0 corrupt=1; storage unchanged on readback.
REQ-033 Assert reset while d_valid=1 and d_ready=0 -> d_valid=0 immediately, stored data reads back 0, no stale D beat.
REQ-034 Random A/D traffic with random backpressure checked by the TL-UL protocol monitor and a reference memory model -> no protocol violations, all data match.
